imu_poll_scheduler: RTL and testbench

- Periodic transaction sequencer for the IMU I2C path.
- Every poll period it issues two burst-read commands to the byte-level I2C master: 6 accelerometer bytes, then 6 gyroscope bytes.
- It assembles the returned bytes into six 10-bit axis words and publishes them together with a one-cycle DataValid pulse.
- It sits between the I2C byte engine and the Accel/Gyro filter stages; its DataValid drives the filters' ReadDone.

---
 rtl/imu_poll_scheduler.sv | 177 +++++++++++++++++
 tb/tb_imu_poll_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_poll_scheduler.sv
// Periodic IMU poller: every poll period issues an accel then a gyro 6-byte burst read
// to the I2C byte master, assembles six 10-bit axis words and publishes them with DataValid.
module imu_poll_scheduler #(
    parameter int unsigned PollDivider = 500000,
    parameter logic [6:0]  AccelAddr   = 7'h53,
    parameter logic [7:0]  AccelReg    = 8'h32,
    parameter logic [6:0]  GyroAddr    = 7'h68,
    parameter logic [7:0]  GyroReg     = 8'h1D
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       Enable,
    output logic       CmdValid,
    input  logic       CmdReady,
    output logic [6:0] CmdDevAddr,
    output logic [7:0] CmdRegAddr,
    output logic [2:0] CmdLen,
    input  logic       RxValid,
    input  logic [7:0] RxByte,
    input  logic       XferDone,
    input  logic       XferError,
    output logic [9:0] AccelX,
    output logic [9:0] AccelY,
    output logic [9:0] AccelZ,
    output logic [9:0] GyroX,
    output logic [9:0] GyroY,
    output logic [9:0] GyroZ,
    output logic       DataValid,
    output logic [7:0] ErrorCount,
    output logic       Overrun
);
    localparam int unsigned     CntW    = $clog2(PollDivider);
    localparam logic [CntW-1:0] LastCnt = CntW'(PollDivider - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC_CMD,
        S_ACC_RX,
        S_GYR_CMD,
        S_GYR_RX,
        S_PUBLISH
    } state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shadow_q [12];
    logic [7:0]      shadow_d [12];
    logic [9:0]      acc_x_q, acc_y_q, acc_z_q;
    logic [9:0]      gyr_x_q, gyr_y_q, gyr_z_q;
    logic [7:0]      err_q;
    logic            ovr_q;

    logic            tick, in_rx, take_byte, good_done, bad_done, publish;
    logic [2:0]      idx_inc;
    logic [3:0]      wr_idx;

    always_comb begin
        tick = Enable && (cnt_q == LastCnt);
        if (!Enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A byte arriving with XferDone is counted before the done condition is judged.
    always_comb begin
        in_rx     = (state_q == S_ACC_RX) || (state_q == S_GYR_RX);
        take_byte = in_rx && RxValid && (idx_q < 3'd6);
        idx_inc   = idx_q + {2'b00, take_byte};
        good_done = in_rx && XferDone && !XferError && (idx_inc == 3'd6);
        bad_done  = in_rx && XferDone && !good_done;
        publish   = (state_q == S_GYR_RX) && good_done;
        wr_idx    = ((state_q == S_GYR_RX) ? 4'd6 : 4'd0) + {1'b0, idx_q};
        idx_d     = ((state_q == S_ACC_CMD) || (state_q == S_GYR_CMD)) ? 3'd0 : idx_inc;
        for (int unsigned i = 0; i < 12; i++) begin
            shadow_d[i] = (take_byte && (wr_idx == 4'(i))) ? RxByte : shadow_q[i];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (tick) state_d = S_ACC_CMD;
            S_ACC_CMD: if (CmdReady) state_d = S_ACC_RX;
            S_ACC_RX: begin
                if (good_done)     state_d = S_GYR_CMD;
                else if (bad_done) state_d = S_IDLE;
            end
            S_GYR_CMD: if (CmdReady) state_d = S_GYR_RX;
            S_GYR_RX: begin
                if (good_done)     state_d = S_PUBLISH;
                else if (bad_done) state_d = S_IDLE;
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CmdValid   = 1'b0;
        CmdDevAddr = '0;
        CmdRegAddr = '0;
        DataValid  = 1'b0;
        case (state_q)
            S_ACC_CMD: begin
                CmdValid   = 1'b1;
                CmdDevAddr = AccelAddr;
                CmdRegAddr = AccelReg;
            end
            S_GYR_CMD: begin
                CmdValid   = 1'b1;
                CmdDevAddr = GyroAddr;
                CmdRegAddr = GyroReg;
            end
            S_PUBLISH: DataValid = 1'b1;
            default: ;
        endcase
    end

    // Axis registers load on the gyro done edge so they change together with DataValid.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            ovr_q   <= 1'b0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            acc_z_q <= '0;
            gyr_x_q <= '0;
            gyr_y_q <= '0;
            gyr_z_q <= '0;
            for (int unsigned i = 0; i < 12; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            if (bad_done && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
            if (tick && (state_q != S_IDLE)) begin
                ovr_q <= 1'b1;
            end
            if (publish) begin
                acc_x_q <= {shadow_d[1][1:0], shadow_d[0]};
                acc_y_q <= {shadow_d[3][1:0], shadow_d[2]};
                acc_z_q <= {shadow_d[5][1:0], shadow_d[4]};
                gyr_x_q <= {shadow_d[6],  shadow_d[7][7:6]};
                gyr_y_q <= {shadow_d[8],  shadow_d[9][7:6]};
                gyr_z_q <= {shadow_d[10], shadow_d[11][7:6]};
            end
        end
    end

    assign CmdLen     = 3'd6;
    assign AccelX     = acc_x_q;
    assign AccelY     = acc_y_q;
    assign AccelZ     = acc_z_q;
    assign GyroX      = gyr_x_q;
    assign GyroY      = gyr_y_q;
    assign GyroZ      = gyr_z_q;
    assign ErrorCount = err_q;
    assign Overrun    = ovr_q;

endmodule

// File: tb/tb_imu_poll_scheduler.sv
// Bench for imu_poll_scheduler: acts as the I2C byte master and compares outputs
// against an arithmetic model of the frame, error and overrun rules.
module tb_imu_poll_scheduler;
    localparam int unsigned PD    = 40;
    localparam logic [6:0]  ACC_A = 7'h53;
    localparam logic [7:0]  ACC_R = 8'h32;
    localparam logic [6:0]  GYR_A = 7'h68;
    localparam logic [7:0]  GYR_R = 8'h1D;
    localparam int unsigned NONE  = 99;

    logic       clk = 1'b0;
    logic       Reset, Enable, CmdReady, RxValid, XferDone, XferError;
    logic [7:0] RxByte;
    logic       CmdValid, DataValid, Overrun;
    logic [6:0] CmdDevAddr;
    logic [7:0] CmdRegAddr, ErrorCount;
    logic [2:0] CmdLen;
    logic [9:0] AccelX, AccelY, AccelZ, GyroX, GyroY, GyroZ;

    always #5 clk = ~clk;

    imu_poll_scheduler #(
        .PollDivider(PD), .AccelAddr(ACC_A), .AccelReg(ACC_R),
        .GyroAddr(GYR_A), .GyroReg(GYR_R)
    ) dut (
        .CLOCK_50(clk), .Reset(Reset), .Enable(Enable),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdDevAddr(CmdDevAddr),
        .CmdRegAddr(CmdRegAddr), .CmdLen(CmdLen),
        .RxValid(RxValid), .RxByte(RxByte), .XferDone(XferDone), .XferError(XferError),
        .AccelX(AccelX), .AccelY(AccelY), .AccelZ(AccelZ),
        .GyroX(GyroX), .GyroY(GyroY), .GyroZ(GyroZ),
        .DataValid(DataValid), .ErrorCount(ErrorCount), .Overrun(Overrun)
    );

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned cyc = 0, last_dv_cyc = 0, dv_interval = 0, dv_seen = 0;
    logic [7:0]  fb [12];
    logic [9:0]  m_acc [3];
    logic [9:0]  m_gyr [3];
    int unsigned m_err = 0, m_pub = 0;
    logic        m_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (DataValid === 1'b1) begin
            dv_interval = cyc - last_dv_cyc;
            last_dv_cyc = cyc;
            dv_seen++;
        end
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
    endtask

    // Little-endian accel keeps the low 10 bits; big-endian gyro keeps bits 15..6.
    task automatic publish_model();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 10'((int'(fb[2*k+1]) * 256 + int'(fb[2*k])) % 1024);
            m_gyr[k] = 10'((int'(fb[6+2*k]) * 256 + int'(fb[7+2*k])) / 64);
        end
        m_pub++;
    endtask

    task automatic chk_axes(input string tag);
        chk({tag, "_AccelX"}, 32'(AccelX), 32'(m_acc[0]));
        chk({tag, "_AccelY"}, 32'(AccelY), 32'(m_acc[1]));
        chk({tag, "_AccelZ"}, 32'(AccelZ), 32'(m_acc[2]));
        chk({tag, "_GyroX"},  32'(GyroX),  32'(m_gyr[0]));
        chk({tag, "_GyroY"},  32'(GyroY),  32'(m_gyr[1]));
        chk({tag, "_GyroZ"},  32'(GyroZ),  32'(m_gyr[2]));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk_axes(tag);
        chk({tag, "_CmdValid"},   32'(CmdValid),   32'(0));
        chk({tag, "_DataValid"},  32'(DataValid),  32'(0));
        chk({tag, "_ErrorCount"}, 32'(ErrorCount), m_err);
        chk({tag, "_Overrun"},    32'(Overrun),    32'(m_ovr));
    endtask

    task automatic wait_cmd(input logic [6:0] addr, input logic [7:0] rg,
                            input int unsigned stall, output bit ok);
        int unsigned n;
        n  = 0;
        ok = 1'b0;
        while (CmdValid !== 1'b1 && n < 4 * PD) begin
            RxValid = ($urandom_range(0, 3) == 0);
            RxByte  = 8'($urandom);
            step();
            n++;
        end
        RxValid = 1'b0;
        chk("cmd_seen", 32'(CmdValid), 32'(1));
        if (CmdValid !== 1'b1) return;
        chk("cmd_addr", 32'(CmdDevAddr), 32'(addr));
        chk("cmd_reg",  32'(CmdRegAddr), 32'(rg));
        chk("cmd_len",  32'(CmdLen),     32'(6));
        for (int unsigned i = 0; i < stall; i++) begin
            CmdReady = 1'b0;
            step();
            chk("stall_valid", 32'(CmdValid),   32'(1));
            chk("stall_addr",  32'(CmdDevAddr), 32'(addr));
            chk("stall_reg",   32'(CmdRegAddr), 32'(rg));
        end
        CmdReady = 1'b1;
        step();
        CmdReady = 1'b0;
        chk("cmd_drop", 32'(CmdValid), 32'(0));
        ok = 1'b1;
    endtask

    task automatic send_bytes(input int unsigned base, input int unsigned nb, input bit err,
                              input bit rnd, input int unsigned drop_idx);
        int unsigned extra, tot;
        bit same;
        extra = (rnd && nb == 6) ? $urandom_range(0, 1) : 0;
        same  = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
        tot   = nb + extra;
        if (tot == 0) same = 1'b0;
        for (int unsigned i = 0; i < tot; i++) begin
            if (rnd && $urandom_range(0, 1) == 1) step();
            if (i == drop_idx) Enable = 1'b0;
            RxValid = 1'b1;
            RxByte  = (i < nb) ? fb[base+i] : 8'($urandom);
            if (same && i == tot - 1) begin
                XferDone  = 1'b1;
                XferError = err;
            end
            step();
            RxValid   = 1'b0;
            XferDone  = 1'b0;
            XferError = 1'b0;
        end
        if (!same) begin
            XferDone  = 1'b1;
            XferError = err;
            step();
            XferDone  = 1'b0;
            XferError = 1'b0;
        end
    endtask

    task automatic frame(input int unsigned acc_n, input bit acc_err, input int unsigned gyr_n,
                         input bit gyr_err, input int unsigned stall, input bit rnd,
                         input int unsigned drop_idx);
        bit ok;
        int unsigned s, cv;
        s = stall + (rnd ? $urandom_range(0, 1) : 0);
        wait_cmd(ACC_A, ACC_R, s, ok);
        if (!ok) return;
        if (s >= PD - 1) m_ovr = 1'b1;
        send_bytes(0, acc_n, acc_err, rnd, NONE);
        if (acc_n != 6 || acc_err) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            chk("acc_err_count", 32'(ErrorCount), m_err);
            cv = 0;
            for (int i = 0; i < 6; i++) begin
                if (CmdValid === 1'b1) cv++;
                step();
            end
            chk("no_gyro_cmd", cv, 0);
            chk_idle_outputs("acc_err");
            return;
        end
        wait_cmd(GYR_A, GYR_R, rnd ? $urandom_range(0, 1) : 0, ok);
        if (!ok) return;
        send_bytes(6, gyr_n, gyr_err, rnd, drop_idx);
        if (gyr_n == 6 && !gyr_err) begin
            publish_model();
            chk("dv_pulse", 32'(DataValid), 32'(1));
            chk_axes("publish");
            step();
            chk("dv_one_cycle", 32'(DataValid), 32'(0));
        end else begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            chk("gyr_err_count", 32'(ErrorCount), m_err);
            chk("gyr_err_no_dv", 32'(DataValid), 32'(0));
            chk_axes("gyr_err");
        end
        chk("overrun", 32'(Overrun), 32'(m_ovr));
        chk("pub_count", dv_seen, m_pub);
    endtask

    initial begin
        int unsigned n, cv, kind;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = '0;
            m_gyr[k] = '0;
        end
        Reset = 1'b1; Enable = 1'b0; CmdReady = 1'b0; RxValid = 1'b0;
        RxByte = '0; XferDone = 1'b0; XferError = 1'b0;
        repeat (3) step();
        chk_idle_outputs("reset");
        Reset  = 1'b0;
        Enable = 1'b1;

        // Nominal frames with the reference byte pattern and a fully ready master.
        for (int f = 0; f < 2; f++) begin
            fb[0] = 8'h01; fb[1] = 8'h02; fb[2]  = 8'hFF; fb[3]  = 8'h03; fb[4]  = 8'h10; fb[5]  = 8'h00;
            fb[6] = 8'h12; fb[7] = 8'h34; fb[8]  = 8'hFF; fb[9]  = 8'hC0; fb[10] = 8'h80; fb[11] = 8'h00;
            frame(6, 0, 6, 0, 0, 0, NONE);
        end
        chk("nom_AccelX", 32'(AccelX), 32'h201);
        chk("nom_AccelY", 32'(AccelY), 32'h3FF);
        chk("nom_AccelZ", 32'(AccelZ), 32'h010);
        chk("nom_GyroX",  32'(GyroX),  32'h048);
        chk("nom_GyroY",  32'(GyroY),  32'h3FF);
        chk("nom_GyroZ",  32'(GyroZ),  32'h200);
        chk("dv_interval", dv_interval, PD);

        for (int f = 0; f < 6; f++) begin
            rand_bytes();
            frame(6, 0, 6, 0, 0, 1, NONE);
        end

        rand_bytes();
        frame(6, 0, $urandom_range(0, 6), 1, 0, 1, NONE);
        chk("nack_err_is_1", 32'(ErrorCount), 32'(1));
        rand_bytes();
        frame(6, 0, 6, 0, 0, 1, NONE);

        for (int f = 0; f < 6; f++) begin
            rand_bytes();
            kind = $urandom_range(0, 3);
            case (kind)
                0: frame($urandom_range(0, 6), 1, 6, 0, 0, 1, NONE);
                1: frame($urandom_range(0, 5), 0, 6, 0, 0, 1, NONE);
                2: frame(6, 0, $urandom_range(0, 5), 0, 0, 1, NONE);
                default: frame(6, 0, $urandom_range(0, 6), 1, 0, 1, NONE);
            endcase
        end

        // Command stalled across a tick: the tick is dropped and only this frame publishes.
        rand_bytes();
        frame(6, 0, 6, 0, 50, 0, NONE);
        chk("overrun_set", 32'(Overrun), 32'(1));
        rand_bytes();
        frame(6, 0, 6, 0, 0, 1, NONE);

        for (int f = 0; f < 256; f++) begin
            rand_bytes();
            frame(4, 0, 6, 0, 0, 1, NONE);
        end
        chk("err_saturated", 32'(ErrorCount), 32'd255);

        rand_bytes();
        wait_cmd(ACC_A, ACC_R, 0, ok);
        for (int i = 0; i < 3; i++) begin
            RxValid = 1'b1;
            RxByte  = fb[i];
            step();
        end
        RxValid = 1'b0;
        Reset   = 1'b1;
        step();
        Reset   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = '0;
            m_gyr[k] = '0;
        end
        m_err = 0;
        m_ovr = 1'b0;
        chk_idle_outputs("mid_reset");
        rand_bytes();
        frame(6, 0, 6, 0, 0, 1, NONE);

        // Enable drops mid gyro burst: frame still publishes, then polling stops.
        rand_bytes();
        frame(6, 0, 6, 0, 0, 0, 3);
        cv = 0;
        for (int unsigned i = 0; i < 3 * PD; i++) begin
            step();
            if (CmdValid === 1'b1) cv++;
        end
        chk("no_cmd_disabled", cv, 0);
        Enable = 1'b1;
        n = 0;
        while (CmdValid !== 1'b1 && n < 2 * PD) begin
            step();
            n++;
        end
        chk("reenable_latency", n, PD);
        rand_bytes();
        frame(6, 0, 6, 0, 0, 1, NONE);
        chk("final_pub_count", dv_seen, m_pub);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
